xbee_msg_rx: RTL and testbench

XBEE_MSG_RX -- requirements
Module: xbee_msg_rx

---
 rtl/xbee_msg_rx.sv | 159 +++++++++++++++
 tb/tb_xbee_msg_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbee_msg_rx.sv
// XBee-style framed byte receiver: SOF, fixed-length payload, optional checksum byte.
// Define XBEE_MSG_CHECKSUM_EN to append and verify a checksum byte after the payload.
module xbee_msg_rx #(
    parameter int                    DATA_WIDTH     = 8,
    parameter logic [DATA_WIDTH-1:0] SOF_BYTE       = 8'h7E,
    parameter int                    PAYLOAD_LEN    = 3,
    parameter int                    TIMEOUT_CYCLES = 50_000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             rx_data,
    input  logic                              rx_rdy,
    input  logic                              msg_ack,
    output logic [PAYLOAD_LEN*DATA_WIDTH-1:0] msg_data,
    output logic                              msg_valid,
    output logic                              frame_err,
    output logic                              overrun
);

    localparam int IDX_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MSG_W = PAYLOAD_LEN * DATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
`ifdef XBEE_MSG_CHECKSUM_EN
        S_CHECK   = 2'd2,
`endif
        S_PAYLOAD = 2'd1
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [MSG_W-1:0]      shadow_q, shadow_d;
    logic [MSG_W-1:0]      msg_data_q, msg_data_d;
    logic                  msg_valid_q, msg_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  overrun_q, overrun_d;
    logic                  rx_rdy_q;

    logic                  accept;
    logic                  complete;
    logic                  cks_bad;
    logic                  timeout;
    logic [DATA_WIDTH-1:0] cks_sum;

    // A byte is taken only on the rising edge of rx_rdy, however long it stays high.
    assign accept  = rx_rdy & ~rx_rdy_q;
    assign cks_sum = sum_q + rx_data;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        shadow_d = shadow_q;
        complete = 1'b0;
        cks_bad  = 1'b0;
        timeout  = 1'b0;
        tmo_d    = (state_q != S_IDLE) ? tmo_q + TMO_W'(1) : tmo_q;

        case (state_q)
            S_IDLE: begin
                if (accept && rx_data == SOF_BYTE) begin
                    state_d = S_PAYLOAD;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    for (int i = 0; i < PAYLOAD_LEN; i++) begin
                        if (idx_q == IDX_W'(i)) shadow_d[i*DATA_WIDTH +: DATA_WIDTH] = rx_data;
                    end
                    sum_d = cks_sum;
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(PAYLOAD_LEN - 1)) begin
`ifdef XBEE_MSG_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d  = S_IDLE;
                        complete = 1'b1;
`endif
                    end
                end
            end
`ifdef XBEE_MSG_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_d  = S_IDLE;
                    complete = (cks_sum == '1);
                    cks_bad  = (cks_sum != '1);
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // An accepted byte always restarts the inter-byte timer, even on the last cycle.
        if (accept) begin
            tmo_d = '0;
        end else if (state_q != S_IDLE && tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout = 1'b1;
            state_d = S_IDLE;
            tmo_d   = '0;
        end

        msg_data_d  = msg_data_q;
        msg_valid_d = msg_valid_q;
        overrun_d   = 1'b0;
        frame_err_d = cks_bad | timeout;
        if (complete) begin
            if (msg_valid_q && !msg_ack) begin
                overrun_d = 1'b1;
            end else begin
                msg_data_d  = shadow_d;
                msg_valid_d = 1'b1;
            end
        end else if (msg_ack) begin
            msg_valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the payload shadow is reset like every other register, so no stale bytes survive a reset.
            state_q     <= S_IDLE;
            idx_q       <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            shadow_q    <= '0;
            msg_data_q  <= '0;
            msg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_rdy_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            shadow_q    <= shadow_d;
            msg_data_q  <= msg_data_d;
            msg_valid_q <= msg_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            rx_rdy_q    <= rx_rdy;
        end
    end

    assign msg_data  = msg_data_q;
    assign msg_valid = msg_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_xbee_msg_rx.sv
// Self-checking bench for xbee_msg_rx against a queue-based frame model.
// Follows the XBEE_MSG_CHECKSUM_EN define of the design build.
module tb_xbee_msg_rx;

    localparam int         PL  = 3;
    localparam int         TMO = 1000;
    localparam logic [7:0] SOF = 8'h7E;
`ifdef XBEE_MSG_CHECKSUM_EN
    localparam int BODY = PL + 1;
`else
    localparam int BODY = PL;
`endif

    logic            clk;
    logic            reset;
    logic [7:0]      rx_data;
    logic            rx_rdy;
    logic            msg_ack;
    logic [PL*8-1:0] msg_data;
    logic            msg_valid;
    logic            frame_err;
    logic            overrun;

    int checks = 0;
    int errors = 0;

    // Reference model state: frame-in-progress flag, collected body bytes, expected outputs.
    bit              in_frame = 1'b0;
    logic [7:0]      body[$];
    logic            exp_valid = 1'b0;
    logic [PL*8-1:0] exp_data = '0;

    xbee_msg_rx #(
        .DATA_WIDTH    (8),
        .SOF_BYTE      (SOF),
        .PAYLOAD_LEN   (PL),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_rdy   (rx_rdy),
        .msg_ack  (msg_ack),
        .msg_data (msg_data),
        .msg_valid(msg_valid),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [7:0] b, input bit ack, output bit e_err, output bit e_ovr);
        bit complete;
        bit good;
        int s;
        e_err    = 1'b0;
        e_ovr    = 1'b0;
        complete = 1'b0;
        good     = 1'b1;
        if (!in_frame) begin
            if (b == SOF) begin
                in_frame = 1'b1;
                body.delete();
            end
        end else begin
            body.push_back(b);
            if (body.size() == BODY) begin
                complete = 1'b1;
                in_frame = 1'b0;
                s = 0;
                for (int i = 0; i < PL; i++) s += int'(body[i]);
`ifdef XBEE_MSG_CHECKSUM_EN
                good = (((s + int'(body[PL])) % 256) == 255);
`endif
            end
        end
        if (complete && !good) e_err = 1'b1;
        if (complete && good) begin
            if (exp_valid && !ack) begin
                e_ovr = 1'b1;
            end else begin
                exp_valid = 1'b1;
                for (int i = 0; i < PL; i++) exp_data[i*8 +: 8] = body[i];
            end
        end else if (ack) begin
            exp_valid = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack, input int hold);
        bit e_err;
        bit e_ovr;
        @(negedge clk);
        rx_data = b;
        rx_rdy  = 1'b1;
        msg_ack = ack;
        @(negedge clk);
        model_accept(b, ack, e_err, e_ovr);
        check("valid", msg_valid, exp_valid);
        check("data", msg_data, exp_data);
        check("frame_err", frame_err, e_err);
        check("overrun", overrun, e_ovr);
        msg_ack = 1'b0;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", msg_valid, exp_valid);
            check("hold_data", msg_data, exp_data);
            check("hold_pulses", {frame_err, overrun}, 2'b00);
        end
        rx_rdy = 1'b0;
        @(negedge clk);
        check("pulse_clear", {frame_err, overrun}, 2'b00);
        check("idle_valid", msg_valid, exp_valid);
    endtask

    task automatic send_frame(input logic [PL*8-1:0] pl, input bit good, input bit ack_last);
        logic [7:0] s;
        s = 8'h00;
        send_byte(SOF, 1'b0, 1);
        for (int i = 0; i < PL; i++) begin
            s = s + pl[i*8 +: 8];
`ifdef XBEE_MSG_CHECKSUM_EN
            send_byte(pl[i*8 +: 8], 1'b0, 1);
`else
            send_byte(pl[i*8 +: 8], (i == PL - 1) ? ack_last : 1'b0, 1);
`endif
        end
`ifdef XBEE_MSG_CHECKSUM_EN
        send_byte(good ? (8'hFF - s) : (8'hFF - s + 8'h01), ack_last, 1);
`else
        if (good) s = s;
`endif
    endtask

    task automatic do_ack();
        @(negedge clk);
        msg_ack = 1'b1;
        @(negedge clk);
        msg_ack   = 1'b0;
        exp_valid = 1'b0;
        check("ack_valid", msg_valid, exp_valid);
        check("ack_data", msg_data, exp_data);
    endtask

    initial begin
        int first_k;
        int pulses;
        reset   = 1'b0;
        rx_rdy  = 1'b0;
        msg_ack = 1'b0;
        rx_data = 8'h00;
        #12;
        check("rst_valid", msg_valid, 1'b0);
        check("rst_data", msg_data, '0);
        check("rst_pulses", {frame_err, overrun}, 2'b00);
        @(negedge clk);
        reset = 1'b1;

        // Ack with nothing valid is ignored.
        do_ack();

        // Good frame, held until acknowledged.
        send_frame(24'h050302, 1'b1, 1'b0);
        check("kat_050302", msg_data, 24'h050302);
        repeat (5) @(negedge clk);
        check("held_valid", msg_valid, 1'b1);
        do_ack();

        // Corrupted checksum (plain good frame when checksum is disabled).
        send_frame(24'h050302, 1'b0, 1'b0);
        do_ack();

        // Leading junk ignored, SOF value inside payload is data, trailing SOF opens a new frame.
        send_byte(8'h11, 1'b0, 1);
        send_frame(24'h02017E, 1'b1, 1'b0);
        check("kat_02017e", msg_data, 24'h02017E);
        do_ack();
        send_byte(SOF, 1'b0, 1);
        send_byte(8'h21, 1'b0, 2);
        send_byte(8'h22, 1'b0, 3);
`ifdef XBEE_MSG_CHECKSUM_EN
        send_byte(8'h23, 1'b0, 1);
        send_byte(8'hFF - 8'h66, 1'b0, 1);
`else
        send_byte(8'h23, 1'b0, 1);
`endif
        check("kat_232221", msg_data, 24'h232221);
        do_ack();

        // Inter-byte timeout, then normal recovery.
        send_byte(SOF, 1'b0, 1);
        send_byte(8'h01, 1'b0, 1);
        first_k = -1;
        pulses  = 0;
        for (int k = 2; k <= TMO + 10; k++) begin
            @(negedge clk);
            if (frame_err) begin
                pulses++;
                if (first_k < 0) first_k = k;
            end
        end
        check("tmo_window", (first_k >= TMO - 5 && first_k <= TMO + 5), 1'b1);
        check("tmo_pulses", pulses, 1);
        check("tmo_valid", msg_valid, exp_valid);
        in_frame = 1'b0;
        send_frame(24'h0C0B0A, 1'b1, 1'b0);
        check("kat_0c0b0a", msg_data, 24'h0C0B0A);
        do_ack();

        // Overrun drop, then completion coinciding with ack.
        send_frame(24'hA1A2A3, 1'b1, 1'b0);
        send_frame(24'hB1B2B3, 1'b1, 1'b0);
        check("ovr_keep", msg_data, 24'hA1A2A3);
        do_ack();
        send_frame(24'hC1C2C3, 1'b1, 1'b0);
        send_frame(24'hD1D2D3, 1'b1, 1'b1);
        check("ack_load", msg_data, 24'hD1D2D3);
        check("ack_load_valid", msg_valid, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1'b0, int'($urandom_range(1, 3)));
            if ($urandom_range(0, 2) == 0) do_ack();
            send_frame(24'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-frame.
        do_ack();
        send_frame(24'h332211, 1'b1, 1'b0);
        send_byte(SOF, 1'b0, 1);
        send_byte(8'h01, 1'b0, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_valid", msg_valid, 1'b0);
        check("arst_data", msg_data, '0);
        check("arst_pulses", {frame_err, overrun}, 2'b00);
        @(negedge clk);
        reset     = 1'b1;
        in_frame  = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
        body.delete();
        send_byte(8'h02, 1'b0, 1);
        send_byte(8'h03, 1'b0, 1);
        send_byte(8'h04, 1'b0, 1);
        send_byte(8'h05, 1'b0, 1);
        check("post_rst_valid", msg_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
